// File: rtl/jt08_adpcm_step.sv
// ADPCM-B nibble decoder step controller; sequences two serial-multiplier ops per code (increment, then step update).
// Define JT08_ADPCM_STEP_SAT_EN to saturate the sample instead of wrapping it modulo 2^16.
module jt08_adpcm_step #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          restart,
  input  logic          din_valid,
  input  logic [3:0]    din,
  output logic          din_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          mul_start,
  output logic [DW-1:0] mul_a,
  output logic [DW-1:0] mul_b,
  input  logic [DW-1:0] mul_d,
  input  logic          mul_working
);

  typedef enum logic [2:0] {IDLE, SX, GX, WX, SD, GD, WD, DONE} state_t;

  state_t      state;
  logic        sign;
  logic [2:0]  mag;
  logic [15:0] x;
  logic [15:0] x_next;
  logic [15:0] delta;
  logic [15:0] x_upd;
  logic [15:0] delta_clamped;
  logic [17:0] dn;
  logic [7:0]  k;

  assign din_ready = (state == IDLE) & ~restart;
  assign busy      = (state != IDLE);
  assign mul_a     = delta;

  always_comb begin
    k = 8'd57;
    case (mag)
      3'd4:    k = 8'd77;
      3'd5:    k = 8'd102;
      3'd6:    k = 8'd128;
      3'd7:    k = 8'd153;
      default: k = 8'd57;
    endcase
  end

  assign dn = {mul_d, 2'b00};

  always_comb begin
    delta_clamped = dn[15:0];
    if (dn < 18'd127)
      delta_clamped = 16'd127;
    else if (dn > 18'd24576)
      delta_clamped = 16'd24576;
  end

`ifdef JT08_ADPCM_STEP_SAT_EN
  logic signed [17:0] x_wide;

  always_comb begin
    x_wide = sign ? $signed({{2{x[15]}}, x}) - $signed({1'b0, mul_d, 1'b0})
                  : $signed({{2{x[15]}}, x}) + $signed({1'b0, mul_d, 1'b0});
    x_upd = x_wide[15:0];
    if (x_wide > 18'sd32767)
      x_upd = 16'h7fff;
    else if (x_wide < -18'sd32768)
      x_upd = 16'h8000;
  end
`else
  // Bits above 15 of the increment cannot affect a result kept modulo 2^16.
  always_comb begin
    x_upd = sign ? x - {mul_d[14:0], 1'b0} : x + {mul_d[14:0], 1'b0};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sign       <= 1'b0;
      mag        <= 3'd0;
      x          <= 16'd0;
      x_next     <= 16'd0;
      delta      <= 16'd127;
      dout       <= 16'd0;
      dout_valid <= 1'b0;
      mul_start  <= 1'b0;
      mul_b      <= 16'd0;
    end else if (restart) begin
      state      <= IDLE;
      x          <= 16'd0;
      delta      <= 16'd127;
      dout       <= 16'd0;
      dout_valid <= 1'b0;
      mul_start  <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (cen) begin
        case (state)
          IDLE: if (din_valid) begin
            sign      <= din[3];
            mag       <= din[2:0];
            mul_b     <= {din[2:0], 1'b1, 12'd0};
            mul_start <= 1'b1;
            state     <= SX;
          end
          SX: begin
            mul_start <= 1'b0;
            state     <= GX;
          end
          GX: state <= WX;
          WX: if (!mul_working) begin
            x_next    <= x_upd;
            mul_b     <= {k, 8'd0};
            mul_start <= 1'b1;
            state     <= SD;
          end
          SD: begin
            mul_start <= 1'b0;
            state     <= GD;
          end
          GD: state <= WD;
          WD: if (!mul_working) begin
            delta <= delta_clamped;
            state <= DONE;
          end
          DONE: begin
            x          <= x_next;
            dout       <= x_next;
            dout_valid <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
